// File: rtl/conv_mac_8_pkg.sv
// Shared definitions for the layer-8 kernel MAC: FSM encoding, default layer
// sizes and the accumulator width derivation.
package conv_mac_8_pkg;

  localparam int KERN_S_8  = 4;
  localparam int COEFF_W_8 = 8;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Wide enough that KERN_SIZE full-scale products can never overflow.
  function automatic int acc_width(input int coeff_w, input int data_w, input int kern);
    return coeff_w + data_w + $clog2(kern);
  endfunction

endpackage

// File: rtl/conv_mac_8_mac_pipe.sv
// Registered multiplier followed by a load/accumulate register.
// acc_nxt exposes the value the accumulator takes at the next edge.
module conv_mac_8_mac_pipe
  import conv_mac_8_pkg::*;
#(
  parameter int COEFF_W = COEFF_W_8,
  parameter int DATA_W  = 16,
  parameter int ACC_W   = acc_width(COEFF_W_8, 16, KERN_S_8)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld_in,
  input  logic                      first_in,
  input  logic signed [COEFF_W-1:0] w,
  input  logic signed [DATA_W-1:0]  x,
  output logic signed [ACC_W-1:0]   acc_nxt
);

  localparam int PROD_W = COEFF_W + DATA_W;

  logic signed [PROD_W-1:0] prod_p0;
  logic                     vld_p0;
  logic                     first_p0;
  logic signed [ACC_W-1:0]  acc_p1;

  // Stage 1: product register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
    end else begin
      vld_p0   <= vld_in;
      first_p0 <= first_in;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_in) prod_p0 <= w * x;
  end

  // Stage 2: accumulator, loaded by the first product of a kernel
  always_comb begin
    acc_nxt = acc_p1;
    if (vld_p0) acc_nxt = first_p0 ? ACC_W'(prod_p0) : acc_p1 + ACC_W'(prod_p0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_p1 <= '0;
    else     acc_p1 <= acc_nxt;
  end

endmodule

// File: rtl/conv_mac_8.sv
// Conv layer 8 kernel MAC: dot product of KERN_SIZE pairs, shift and saturate.
// Build option: CONV_RELU_EN clamps negative results to zero.
module conv_mac_8
  import conv_mac_8_pkg::*;
#(
  parameter int KERN_SIZE = KERN_S_8,
  parameter int COEFF_W   = COEFF_W_8,
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 8
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [COEFF_W-1:0] weight_V_dout,
  input  logic               weight_V_empty_n,
  output logic               weight_V_read,
  input  logic [DATA_W-1:0]  input_V_dout,
  input  logic               input_V_empty_n,
  output logic               input_V_read,
  output logic [OUT_W-1:0]   output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);

  localparam int ACC_W = acc_width(COEFF_W, DATA_W, KERN_SIZE);
  localparam int CNT_W = $clog2(KERN_SIZE);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    cnt_last;
  logic                    rd_en;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [OUT_W-1:0] res_q;

  function automatic logic signed [OUT_W-1:0] sat_res(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
`ifdef CONV_RELU_EN
    if (s < 0) s = '0;
`endif
    if (s > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (s < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return s[OUT_W-1:0];
  endfunction

  assign cnt_last = (cnt_q == CNT_W'(KERN_SIZE - 1));

  // Strobes are gated by reset so nothing is popped or pushed while held.
  always_comb begin
    state_d        = state_q;
    rd_en          = 1'b0;
    output_V_write = 1'b0;
    unique case (state_q)
      ST_ACC: begin
        if (weight_V_empty_n && input_V_empty_n && !ap_rst) begin
          rd_en = 1'b1;
          if (cnt_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (output_V_full_n && !ap_rst) begin
          output_V_write = 1'b1;
          state_d        = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  assign weight_V_read = rd_en;
  assign input_V_read  = rd_en;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (rd_en) cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
    end
  end

  conv_mac_8_mac_pipe #(
    .COEFF_W (COEFF_W),
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W)
  ) u_mac_pipe (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .vld_in   (rd_en),
    .first_in (cnt_q == '0),
    .w        (weight_V_dout),
    .x        (input_V_dout),
    .acc_nxt  (acc_nxt)
  );

  // Result register: DRAIN folds in the last product as the result is captured
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)                 res_q <= '0;
    else if (state_q == ST_DRAIN) res_q <= sat_res(acc_nxt);
  end

  assign output_V_din = res_q;

endmodule

// File: tb/tb_conv_mac_8.sv
// Scoreboard bench for conv_mac_8: FIFO models on both inputs, expected
// results queued at stimulus time and consumed by a cycle monitor.
module tb_conv_mac_8;

  localparam int KS = 4;
  localparam int CW = 8;
  localparam int DW = 16;
  localparam int OW = 16;
  localparam int SH = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic [CW-1:0] weight_V_dout;
  logic          weight_V_empty_n;
  logic          weight_V_read;
  logic [DW-1:0] input_V_dout;
  logic          input_V_empty_n;
  logic          input_V_read;
  logic [OW-1:0] output_V_din;
  logic          output_V_full_n;
  logic          output_V_write;

  always #5 ap_clk = ~ap_clk;

  conv_mac_8 #(
    .KERN_SIZE (KS),
    .COEFF_W   (CW),
    .DATA_W    (DW),
    .OUT_W     (OW),
    .SHIFT     (SH)
  ) dut (
    .ap_clk           (ap_clk),
    .ap_rst           (ap_rst),
    .weight_V_dout    (weight_V_dout),
    .weight_V_empty_n (weight_V_empty_n),
    .weight_V_read    (weight_V_read),
    .input_V_dout     (input_V_dout),
    .input_V_empty_n  (input_V_empty_n),
    .input_V_read     (input_V_read),
    .output_V_din     (output_V_din),
    .output_V_full_n  (output_V_full_n),
    .output_V_write   (output_V_write)
  );

  int checks = 0;
  int failures = 0;

  logic [CW-1:0] wq[$];
  logic [DW-1:0] iq[$];
  int            exp_q[$];

  bit w_tog_mode = 0, rand_gate = 0, bp_rand = 0, full_block = 0;
  int cyc = 0, rd_cnt = 0, done_k = 0, wr_k = 0, last_rd = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: full-precision dot product, arithmetic shift, optional ReLU, clamp.
  function automatic int model(input int w[KS], input int x[KS]);
    longint acc, s, hi, lo;
    acc = 0;
    for (int i = 0; i < KS; i++) acc += longint'(w[i]) * longint'(x[i]);
    s = acc >>> SH;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return int'(s);
  endfunction

  task automatic push_kernel(input int w[KS], input int x[KS]);
    logic [31:0] wv, xv;
    for (int i = 0; i < KS; i++) begin
      wv = w[i];
      xv = x[i];
      wq.push_back(wv[CW-1:0]);
      iq.push_back(xv[DW-1:0]);
    end
    exp_q.push_back(model(w, x));
  endtask

  task automatic push_random_kernel();
    int w[KS], x[KS];
    for (int i = 0; i < KS; i++) begin
      w[i] = int'($urandom_range(0, 255)) - 128;
      x[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    push_kernel(w, x);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 3000; i++) begin
      if (wq.size() == 0 && iq.size() == 0 && exp_q.size() == 0) begin
        idle = 1;
        break;
      end
      @(negedge ap_clk);
    end
    check("idle_timeout", idle, 1);
  endtask

  // FIFO-side driver: updates input presentation just after each active edge.
  initial begin
    bit w_ok, i_ok, tog;
    tog = 0;
    weight_V_empty_n = 0;
    input_V_empty_n  = 0;
    weight_V_dout    = '0;
    input_V_dout     = '0;
    output_V_full_n  = 1;
    forever begin
      @(posedge ap_clk);
      #1;
      tog  = ~tog;
      w_ok = (wq.size() > 0) && (w_tog_mode ? tog : (rand_gate ? ($urandom_range(0, 2) != 0) : 1'b1));
      i_ok = (iq.size() > 0) && (rand_gate ? ($urandom_range(0, 2) != 0) : 1'b1);
      weight_V_empty_n = w_ok;
      input_V_empty_n  = i_ok;
      weight_V_dout    = w_ok ? wq[0] : CW'($urandom);
      input_V_dout     = i_ok ? iq[0] : DW'($urandom);
      output_V_full_n  = full_block ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: checks strobes against the protocol and results against the scoreboard.
  always @(negedge ap_clk) begin
    bit pending, exp_rd, exp_wr;
    cyc++;
    if (!ap_rst) begin
      pending = done_k > wr_k;
      exp_rd  = weight_V_empty_n && input_V_empty_n && !pending;
      exp_wr  = pending && (cyc >= last_rd + 2) && output_V_full_n;
      check("weight_read", weight_V_read, exp_rd);
      check("input_read", input_V_read, exp_rd);
      check("write", output_V_write, exp_wr);
      if (pending && cyc >= last_rd + 2)
        check("result", int'($signed(output_V_din)), (exp_q.size() > 0) ? exp_q[0] : 0);
      if (weight_V_read && input_V_read) begin
        if (wq.size() > 0) void'(wq.pop_front());
        if (iq.size() > 0) void'(iq.pop_front());
        rd_cnt++;
        if (rd_cnt == KS) begin
          rd_cnt  = 0;
          done_k++;
          last_rd = cyc;
        end
      end
      if (output_V_write) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        wr_k++;
      end
    end
  end

  initial begin
    ap_rst = 1;
    repeat (2) @(negedge ap_clk);
    check("rst_weight_read", weight_V_read, 0);
    check("rst_input_read", input_V_read, 0);
    check("rst_write", output_V_write, 0);
    check("rst_din", output_V_din, 0);
    @(posedge ap_clk);
    #1 ap_rst = 0;

    push_kernel('{1, 2, 3, 4}, '{256, 256, 256, 256});
    wait_idle();
    push_kernel('{-128, -128, -128, -128}, '{32767, 32767, 32767, 32767});
    push_kernel('{127, 127, 127, 127}, '{32767, 32767, 32767, 32767});
    push_kernel('{64, 0, 0, 0}, '{1200, 7, -9, 11});
    push_kernel('{64, 0, 0, 0}, '{-1200, 3, 5, -2});
    wait_idle();

    // Weight FIFO alternates empty/non-empty
    w_tog_mode = 1;
    repeat (3) push_random_kernel();
    push_kernel('{1, 2, 3, 4}, '{256, 256, 256, 256});
    wait_idle();
    w_tog_mode = 0;

    // Output held full for several cycles while a result waits
    full_block = 1;
    push_kernel('{-3, 5, 7, -1}, '{1000, -2000, 3000, 4000});
    for (int i = 0; i < 200 && done_k == wr_k; i++) @(negedge ap_clk);
    repeat (5) @(posedge ap_clk);
    #1 full_block = 0;
    wait_idle();

    rand_gate = 1;
    bp_rand   = 1;
    repeat (25) push_random_kernel();
    wait_idle();
    rand_gate = 0;
    bp_rand   = 0;

    // Reset after two of four pairs; the partial sum must not leak
    for (int i = 0; i < 2; i++) begin
      wq.push_back(8'd9);
      iq.push_back(16'd4000);
    end
    for (int i = 0; i < 200 && wq.size() > 0; i++) @(negedge ap_clk);
    @(posedge ap_clk);
    #1 ap_rst = 1;
    rd_cnt = 0;
    repeat (2) begin
      @(negedge ap_clk);
      check("midrst_read", weight_V_read | input_V_read, 0);
      check("midrst_write", output_V_write, 0);
      check("midrst_din", output_V_din, 0);
    end
    @(posedge ap_clk);
    #1 ap_rst = 0;
    push_kernel('{1, 1, 1, 1}, '{1280, 1280, 1280, 1280});
    wait_idle();
    check("kernels_written", wr_k, done_k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
